// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory image loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package imem_pkg;

    // Default instruction memory size in bytes.
    localparam int IMEM_DEPTH = 64;

    // Width of the frame length field and of the data byte counter.
    localparam int LEN_W = 16;

    // Loader sequencing: header bytes, payload, trailing checksum, then park.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5
    } loader_state_t;

    // True while a frame is being received; the loader only takes bytes then.
    function automatic logic in_frame(input loader_state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHK);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into instruction memory.
// Latency: each accepted data byte is written one cycle later (registered write port).
// Backpressure: s_ready depends on state only; stalls on s_valid gaps have no side effects.
module imem_loader
    import imem_pkg::*;
#(
    parameter int                 DEPTH  = IMEM_DEPTH,
    parameter int                 ADDR_W = 64,
    parameter logic [ADDR_W-1:0]  BASE   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_chk,
    output logic              err_ovf,
    output logic              cpu_hold
);

    // Counter is widened by one bit so DEPTH up to 2^LEN_W compares correctly.
    localparam logic [LEN_W:0] DEPTH_CMP = (LEN_W + 1)'(DEPTH);

    loader_state_t     state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        xor_q, xor_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              err_chk_q, err_chk_d;
    logic              err_ovf_q, err_ovf_d;
    logic              cpu_hold_q, cpu_hold_d;

    logic              rx_on;
    logic              xfer;
    logic [LEN_W-1:0]  cnt_inc;
    logic [LEN_W-1:0]  len_full;
    logic              in_mem;
    logic              chk_bad;

    assign rx_on    = in_frame(state_q);
    assign xfer     = s_valid & rx_on;
    assign cnt_inc  = cnt_q + LEN_W'(1);
    // Length as it will be once the high byte currently on the bus is taken.
    assign len_full = {s_data, len_q[7:0]};
    assign in_mem   = ({1'b0, cnt_q} < DEPTH_CMP);
    assign chk_bad  = (s_data != xor_q);

    assign s_ready   = rx_on;
    assign busy      = rx_on;
    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err_chk   = err_chk_q;
    assign err_ovf   = err_ovf_q;
    assign cpu_hold  = cpu_hold_q;

    // Next-state logic: frame parsing, write generation, checksum and status flags.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        xor_d       = xor_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = done_q;
        err_chk_d   = err_chk_q;
        err_ovf_d   = err_ovf_q;
        cpu_hold_d  = cpu_hold_q;

        case (state_q)
            IDLE, DONE: begin
                // A new load invalidates the previous result and re-holds the CPU.
                if (start) begin
                    state_d    = LEN_LO;
                    len_d      = '0;
                    cnt_d      = '0;
                    xor_d      = '0;
                    done_d     = 1'b0;
                    err_chk_d  = 1'b0;
                    err_ovf_d  = 1'b0;
                    cpu_hold_d = 1'b1;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = s_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d   = len_full;
                    cnt_d   = '0;
                    xor_d   = '0;
                    // Empty image skips straight to the checksum byte.
                    state_d = (len_full == '0) ? CHK : DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    xor_d = xor_q ^ s_data;
                    cnt_d = cnt_inc;
                    if (in_mem) begin
                        mem_we_d    = 1'b1;
                        mem_waddr_d = BASE + ADDR_W'(cnt_q);
                        mem_wdata_d = s_data;
                    end else begin
                        // Excess bytes are consumed so the frame stays aligned.
                        err_ovf_d = 1'b1;
                    end
                    if (cnt_inc == len_q) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (xfer) begin
                    err_chk_d  = chk_bad;
                    cpu_hold_d = chk_bad | err_ovf_q;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset parks the loader idle with the CPU held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            xor_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_chk_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
            cpu_hold_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            xor_q       <= xor_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_chk_q   <= err_chk_d;
            err_ovf_q   <= err_ovf_d;
            cpu_hold_q  <= cpu_hold_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: drives framed images and scoreboards every memory write.
// Latency: expects each data byte's write one cycle after its transfer.
// Backpressure: exercises back-to-back and gapped s_valid streams.
module tb_imem_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 64;

    logic              clk;
    logic              rst;
    logic              start;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;
    logic              err_chk;
    logic              err_ovf;
    logic              cpu_hold;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    // Expected writes: {addr[63:0], data[7:0]}.
    logic [71:0] sb_q [$];
    logic [7:0]  img [0:127];

    imem_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BASE   ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err_chk   (err_chk),
        .err_ovf   (err_ovf),
        .cpu_hold  (cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            logic [71:0] e;
            we_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_write", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("write_addr", mem_waddr, e[71:8]);
                check("write_data", {56'd0, mem_wdata}, {56'd0, e[7:0]});
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers one byte and waits for it to be taken; optional idle cycle before it.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit ok;
        ok = 1'b0;
        if (gap) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (s_ready) ok = 1'b1;
            @(negedge clk);
        end
        if (!ok) check("xfer_timeout", 64'd0, 64'd1);
    endtask

    // Sends start plus a whole frame of img[0..n-1]; queues the writes that must appear.
    task automatic run_frame(input int n, input logic [7:0] chk, input bit gaps);
        pulse_start();
        send_byte(n[7:0], gaps);
        send_byte(n[15:8], gaps);
        for (int k = 0; k < n; k++) begin
            if (k < DEPTH) sb_q.push_back({64'(k), img[k]});
            send_byte(img[k], gaps);
        end
        send_byte(chk, gaps);
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_flags(input string t, input logic d, input logic ec,
                               input logic eo, input logic ch);
        check({t, "_done"},     {63'd0, done},     {63'd0, d});
        check({t, "_busy"},     {63'd0, busy},     64'd0);
        check({t, "_err_chk"},  {63'd0, err_chk},  {63'd0, ec});
        check({t, "_err_ovf"},  {63'd0, err_ovf},  {63'd0, eo});
        check({t, "_cpu_hold"}, {63'd0, cpu_hold}, {63'd0, ch});
        check({t, "_sb_empty"}, 64'(sb_q.size()),  64'd0);
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;

        // 1: reset values, then idle ignores a valid stream without start
        repeat (2) @(negedge clk);
        check("rst_s_ready",  {63'd0, s_ready},  64'd0);
        check("rst_mem_we",   {63'd0, mem_we},   64'd0);
        check("rst_waddr",    mem_waddr,         64'd0);
        check("rst_busy",     {63'd0, busy},     64'd0);
        check("rst_done",     {63'd0, done},     64'd0);
        check("rst_cpu_hold", {63'd0, cpu_hold}, 64'd1);
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h5A;
        repeat (4) @(negedge clk);
        check("idle_s_ready", {63'd0, s_ready}, 64'd0);
        check("idle_busy",    {63'd0, busy},    64'd0);
        check("idle_we_cnt",  64'(we_cnt),      64'd0);
        s_valid = 1'b0;
        @(negedge clk);

        // 2: clean 4-byte load, back-to-back
        img[0] = 8'h13; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h00;
        we_cnt = 0;
        run_frame(4, 8'h13, 1'b0);
        check("clean_we_cnt", 64'(we_cnt), 64'd4);
        check_flags("clean", 1'b1, 1'b0, 1'b0, 1'b0);

        // 3: same frame with s_valid gaps between every byte
        we_cnt = 0;
        run_frame(4, 8'h13, 1'b1);
        check("gap_we_cnt", 64'(we_cnt), 64'd4);
        check_flags("gap", 1'b1, 1'b0, 1'b0, 1'b0);

        // 4: bad checksum, then a new start clears the error
        img[0] = 8'hAA; img[1] = 8'h55;
        we_cnt = 0;
        run_frame(2, 8'h00, 1'b0);
        check("badchk_we_cnt", 64'(we_cnt), 64'd2);
        check_flags("badchk", 1'b1, 1'b1, 1'b0, 1'b1);
        pulse_start();
        check("restart_err_chk",  {63'd0, err_chk},  64'd0);
        check("restart_done",     {63'd0, done},     64'd0);
        check("restart_busy",     {63'd0, busy},     64'd1);
        check("restart_cpu_hold", {63'd0, cpu_hold}, 64'd1);

        // 5: overflow, 66 bytes into 64-byte memory (start ignored while busy)
        for (int k = 0; k < 66; k++) img[k] = 8'h01;
        we_cnt = 0;
        run_frame(66, 8'h00, 1'b0);
        check("ovf_we_cnt", 64'(we_cnt), 64'd64);
        check_flags("ovf", 1'b1, 1'b0, 1'b1, 1'b1);

        // 6: reset in the middle of the payload
        pulse_start();
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        sb_q.push_back({64'd0, 8'h11});
        send_byte(8'h11, 1'b0);
        sb_q.push_back({64'd1, 8'h22});
        send_byte(8'h22, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_mem_we",  {63'd0, mem_we},  64'd0);
        check("midrst_busy",    {63'd0, busy},    64'd0);
        check("midrst_s_ready", {63'd0, s_ready}, 64'd0);
        check("midrst_waddr",   mem_waddr,        64'd0);
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_sb_empty", 64'(sb_q.size()), 64'd0);

        img[0] = 8'hAB; img[1] = 8'hCD;
        we_cnt = 0;
        run_frame(2, 8'h66, 1'b0);
        check("postrst_we_cnt", 64'(we_cnt), 64'd2);
        check_flags("postrst", 1'b1, 1'b0, 1'b0, 1'b0);

        // Empty image
        we_cnt = 0;
        run_frame(0, 8'h00, 1'b0);
        check("empty_we_cnt", 64'(we_cnt), 64'd0);
        check_flags("empty", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
